// File: rtl/window3x3_gen.sv
// Streaming 3x3 window generator: two IMG_W-deep line buffers feed a 3x3
// register window that is packed in filter3x3 inMatrix order.
module window3x3_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  sof,
  input  logic                  pix_valid,
  input  logic [DATA_W-1:0]     pix_in,
  output logic                  win_valid,
  output logic [9*DATA_W-1:0]   win_out,
  output logic                  frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [DATA_W-1:0] r_lb0 [IMG_W];
  logic [DATA_W-1:0] r_lb1 [IMG_W];
  logic [DATA_W-1:0] r_win [9];
  logic              r_win_valid;
  logic              r_frame_done;

  logic              w_accept;
  logic              w_sof_q;
  logic [CW-1:0]     w_col_cur;
  logic [RW-1:0]     w_row_cur;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_interior;
  logic [DATA_W-1:0] w_lb0_tap;
  logic [DATA_W-1:0] w_lb1_tap;

  assign w_accept   = ena & pix_valid;
  assign w_sof_q    = ena & sof;
  // sof relabels the current pixel as (0,0) before any position decision
  assign w_col_cur  = sof ? '0 : r_col;
  assign w_row_cur  = sof ? '0 : r_row;
  assign w_col_last = (w_col_cur == COL_LAST);
  assign w_row_last = (w_row_cur == ROW_LAST);
  assign w_interior = (w_col_cur >= CW'(2)) && (w_row_cur >= RW'(2));
  assign w_lb0_tap  = r_lb0[IMG_W-1];
  assign w_lb1_tap  = r_lb1[IMG_W-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : w_row_cur + 1'b1;
      end else begin
        r_col <= w_col_cur + 1'b1;
        r_row <= w_row_cur;
      end
    end else if (w_sof_q) begin
      r_col <= '0;
      r_row <= '0;
    end
  end

  // lb0 tap is the pixel one row up in this column, lb1 tap two rows up
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < IMG_W; i++) begin
        r_lb0[i] <= '0;
        r_lb1[i] <= '0;
      end
    end else if (w_accept) begin
      r_lb0[0] <= pix_in;
      r_lb1[0] <= w_lb0_tap;
      for (int i = 1; i < IMG_W; i++) begin
        r_lb0[i] <= r_lb0[i-1];
        r_lb1[i] <= r_lb1[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) begin
        r_win[i] <= '0;
      end
    end else if (w_accept) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= w_lb1_tap;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= w_lb0_tap;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (ena) begin
      r_win_valid  <= w_accept & w_interior;
      r_frame_done <= w_accept & w_col_last & w_row_last;
    end
  end

  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;
  assign win_out    = {r_win[0], r_win[1], r_win[2],
                       r_win[3], r_win[4], r_win[5],
                       r_win[6], r_win[7], r_win[8]};

endmodule

// File: tb/tb_window3x3_gen.sv
// Scoreboard bench for window3x3_gen: an image-array reference model predicts
// per-edge flags and windows; a monitor pops and compares after each edge.
module tb_window3x3_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ena = 1'b0;
  logic             sof = 1'b0;
  logic             pix_valid = 1'b0;
  logic [DW-1:0]    pix_in = '0;
  logic             win_valid;
  logic [9*DW-1:0]  win_out;
  logic             frame_done;

  window3x3_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .ena(ena), .sof(sof), .pix_valid(pix_valid),
    .pix_in(pix_in), .win_valid(win_valid), .win_out(win_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic ena;
    logic pv;
    logic exp_valid;
    logic exp_fd;
  } edge_t;

  edge_t        eq[$];
  logic [71:0]  wq[$];
  int           n_cmp = 0;
  int           n_fail = 0;

  // reference model state
  logic [DW-1:0] img [H][W];
  int            idx = 0;
  logic          m_valid = 1'b0;
  logic          m_fd = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] window_at(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = r - 2; i <= r; i++)
      for (int j = c - 2; j <= c; j++)
        w = {w[63:0], img[i][j]};
    return w;
  endfunction

  task automatic step(input logic r, input logic en, input logic s, input logic v,
                      input logic [DW-1:0] p);
    edge_t e;
    int rr, cc;
    @(negedge clk);
    rst = r; ena = en; sof = s; pix_valid = v; pix_in = p;
    if (!r) begin
      idx = 0; m_valid = 1'b0; m_fd = 1'b0;
    end else if (en) begin
      if (s) idx = 0;
      m_valid = 1'b0; m_fd = 1'b0;
      if (v) begin
        rr = idx / W;
        cc = idx % W;
        img[rr][cc] = p;
        if (rr >= 2 && cc >= 2) begin
          m_valid = 1'b1;
          wq.push_back(window_at(rr, cc));
        end
        if (idx == W*H - 1) m_fd = 1'b1;
        idx = (idx + 1) % (W*H);
      end
    end
    e.rst = r; e.ena = en; e.pv = v; e.exp_valid = m_valid; e.exp_fd = m_fd;
    eq.push_back(e);
  endtask

  // gap_stall=1: ena low with sof/pix_valid high (must be ignored); else a pix_valid bubble
  task automatic send_frame(input int n, input bit with_sof, input int gap_at,
                            input int gap_len, input bit gap_stall);
    for (int p = 1; p <= n; p++) begin
      step(1'b1, 1'b1, with_sof && (p == 1), 1'b1, DW'(p));
      if (p == gap_at)
        for (int g = 0; g < gap_len; g++)
          step(1'b1, !gap_stall, gap_stall, gap_stall, 8'hEE);
    end
  endtask

  // monitor
  initial begin
    edge_t e;
    logic [71:0] prev_out;
    prev_out = '0;
    forever begin
      @(posedge clk);
      #2;
      if (eq.size() > 0) begin
        e = eq.pop_front();
        chk("win_valid", {71'd0, win_valid}, {71'd0, e.exp_valid});
        chk("frame_done", {71'd0, frame_done}, {71'd0, e.exp_fd});
        if (!e.rst)
          chk("reset win_out", win_out, 72'd0);
        else if (!e.ena)
          chk("stall hold win_out", win_out, prev_out);
        else if (!e.pv)
          chk("idle hold win_out", win_out, prev_out);
        else if (e.exp_valid) begin
          if (wq.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL window: got %h expected none queued", win_out);
          end else
            chk("window", win_out, wq.pop_front());
        end
        prev_out = win_out;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
    // T1 with a literal check of the first window
    for (int p = 1; p <= 11; p++) step(1'b1, 1'b1, p == 1, 1'b1, DW'(p));
    @(posedge clk); #2;
    chk("T1 first window", win_out, 72'h01_02_03_05_06_07_09_0a_0b);
    chk("T1 first valid", {71'd0, win_valid}, 72'd1);
    for (int p = 12; p <= 16; p++) step(1'b1, 1'b1, 1'b0, 1'b1, DW'(p));
    // T2: back-to-back frames
    send_frame(16, 1'b1, 0, 0, 1'b0);
    send_frame(16, 1'b1, 0, 0, 1'b0);
    // T3: bubbles and stalls between pixels 11 and 12
    send_frame(16, 1'b1, 11, 2, 1'b0);
    send_frame(16, 1'b1, 11, 3, 1'b1);
    send_frame(16, 1'b1, 15, 2, 1'b1);
    send_frame(16, 1'b1, 16, 3, 1'b1);
    // T4: reset mid-frame, then a frame without sof
    send_frame(9, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
    send_frame(16, 1'b0, 0, 0, 1'b0);
    // T5: sof mid-frame
    send_frame(6, 1'b1, 0, 0, 1'b0);
    send_frame(16, 1'b1, 0, 0, 1'b0);
    // T6: reset has priority over ena/sof/pix_valid
    send_frame(5, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hAA);
    send_frame(16, 1'b0, 0, 0, 1'b0);
    // sof without a pixel resets position
    send_frame(7, 1'b1, 0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    send_frame(16, 1'b0, 0, 0, 1'b0);
    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(99) != 0, $urandom_range(9) != 0, $urandom_range(39) == 0,
           $urandom_range(4) != 0, DW'($urandom));
    end
    send_frame(16, 1'b1, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #3;
    chk("windows drained", 72'(wq.size()), 72'd0);
    chk("edges drained", 72'(eq.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
